alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares the single 32-bit integer ALU (ADD/SUB/AND/OR, 4-bit op code, Zero flag)
//   between two requesters: req0 = integer execute path, req1 = address/branch helper.
//   Each request is accepted with a valid/ready handshake. Operands and op code are
//   registered before they drive the ALU. The result and Zero flag are registered and
//   returned to the owning requester with a valid/ready handshake.
//   At most one operation is in flight. The ALU itself sits outside this block.
// PARAMETERS
//   WIDTH  32  operand/result width; must match the ALU data width
//   OPW    4   ALU op-code width (0000 ADD, 0001 SUB, 0010 AND, 0011 OR)
// PORTS
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   req0_valid   in   1      requester 0 has an operation
//   req0_ready   out  1      requester 0 operation accepted this cycle
//   req0_a       in   WIDTH  requester 0 operand A
//   req0_b       in   WIDTH  requester 0 operand B
//   req0_op      in   OPW    requester 0 op code
//   rsp0_valid   out  1      result for requester 0 available
//   rsp0_ready   in   1      requester 0 consumes result
//   req1_*       same as req0_*, for requester 1
//   rsp1_*       same as rsp0_*, for requester 1
//   rsp_result   out  WIDTH  registered ALU result (shared by both rsp ports)
//   rsp_zero     out  1      registered ALU Zero flag
//   alu_a        out  WIDTH  to ALU operand A
//   alu_b        out  WIDTH  to ALU operand B
//   alu_op       out  OPW    to ALU op code
//   alu_result   in   WIDTH  from ALU result
//   alu_zero     in   1      from ALU Zero flag
//   busy         out  1      1 whenever state != IDLE
// BEHAVIOUR
//   Reset values:
//     - state IDLE; op/result registers 0, so alu_a=alu_b=0 and alu_op=0000.
//     - rsp_result=0, rsp_zero=0; every *_ready and *_valid output 0; busy=0.
//     - last_grant=1, so requester 0 wins the first tie.
//   FSM IDLE -> EXEC -> RESP -> IDLE:
//     IDLE: grant = (one valid) ? that requester : (both valid) ? !last_grant : none.
//       - reqN_ready = (state==IDLE) & grantN. It is combinational from valid and
//         is never asserted for both requesters.
//       - On the handshake, latch a/b/op into the op registers, record the owner,
//         and go to EXEC.
//     EXEC: the ALU is driven from the op registers. At the clock edge, latch
//       alu_result/alu_zero into rsp_result/rsp_zero, then go to RESP.
//     RESP: rspN_valid=1 for the owner only. rsp_result/rsp_zero are held stable.
//       On rspN_ready, set last_grant=owner and return to IDLE.
//   Timing:
//     - Accept at edge T gives rsp valid from cycle T+2.
//     - With rsp_ready tied 1, one operation completes every 3 cycles.
//     - A new request is never accepted in the RESP cycle (no overlap).
//   alu_a/alu_b/alu_op change only on request acceptance. They are stable for the
//     whole EXEC cycle; the ALU is combinational with a single-cycle path.
//   Requester rules:
//     - Valid and operands must be held until ready.
//     - Dropping valid before ready withdraws the request; there is no side effect.
//   rsp stall: the owner may hold rsp_ready low indefinitely. The other requester
//     waits with ready=0.
//   Op codes 0100-1111 are passed through unchecked. The ALU returns result 0 and
//     Zero=1, and the arbiter returns those values.
//   Arithmetic wrap-around (e.g. 0xFFFFFFFF + 1) is the ALU's concern. The result is
//     returned unmodified.
//   Reset asserted mid-operation:
//     - The in-flight operation is discarded with no response.
//     - All outputs return to their reset values immediately (asynchronous).
// CONFIGURATION
//   ALU_ARB_FIXED_PRIO_EN
//     defined:   requester 0 always wins when both are valid; last_grant is unused.
//     undefined: round-robin on ties (default), alternating after each completed op.
// TESTING
//   1. Single op: req0 ADD a=5, b=7 -> req0_ready at T; rsp0_valid at T+2;
//      rsp_result=12, rsp_zero=0.
//   2. Zero flag: req1 SUB a=0x10, b=0x10 -> rsp1_valid, rsp_result=0, rsp_zero=1;
//      rsp0_valid stays 0.
//   3. Tie: both valid continuously (req0 AND 0xF0&0xFF, req1 OR 0x0F|0xF0), rsp_ready=1
//      -> grants 0,1,0,1; results 0xF0 and 0xFF alternate, 3 cycles each.
//   4. Stall: hold rsp0_ready=0 for 10 cycles while req1 is valid
//      -> rsp_result held at 12; req1_ready=0 throughout; req1 is granted in the IDLE
//      cycle after the rsp0 handshake.
//   5. Reset mid-EXEC: pull rst_n low during EXEC -> busy=0, no rsp_valid, alu_op=0000
//      in the same cycle.
//   6. ALU_ARB_FIXED_PRIO_EN defined, both valid for 4 ops -> req0 granted every time.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external 32-bit ALU between two valid/ready requesters, one op in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0; default is round-robin on ties.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OPW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [OPW-1:0]   req0_op_i,
    output logic             rsp0_valid_o,
    input  logic             rsp0_ready_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [OPW-1:0]   req1_op_i,
    output logic             rsp1_valid_o,
    input  logic             rsp1_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_zero_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [OPW-1:0]   alu_op_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_zero_i,
    output logic             busy_o
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             grant0, grant1;
    logic             rsp_hs;

    assign rsp_hs = (state_q == StResp) & (owner_q ? rsp1_ready_i : rsp0_ready_i);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign grant0 = req0_valid_i;
    assign grant1 = req1_valid_i & ~req0_valid_i;
`else
    // last_grant_q holds the owner of the last completed op; the other side wins the next tie.
    logic last_grant_q, last_grant_d;

    assign grant0 = req0_valid_i & (~req1_valid_i | last_grant_q);
    assign grant1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);

    always_comb begin
        last_grant_d = last_grant_q;
        if (rsp_hs) begin
            last_grant_d = owner_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign req0_ready_o = (state_q == StIdle) & grant0;
    assign req1_ready_o = (state_q == StIdle) & grant1;
    assign rsp0_valid_o = (state_q == StResp) & ~owner_q;
    assign rsp1_valid_o = (state_q == StResp) & owner_q;
    assign busy_o       = (state_q != StIdle);
    assign rsp_result_o = result_q;
    assign rsp_zero_o   = zero_q;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign alu_op_o     = op_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        unique case (state_q)
            StIdle: begin
                if (req0_ready_o | req1_ready_o) begin
                    state_d = StExec;
                    owner_d = req1_ready_o;
                    a_d     = req1_ready_o ? req1_a_i  : req0_a_i;
                    b_d     = req1_ready_o ? req1_b_i  : req0_b_i;
                    op_d    = req1_ready_o ? req1_op_i : req0_op_i;
                end
            end
            StExec: begin
                result_d = alu_result_i;
                zero_d   = alu_zero_i;
                state_d  = StResp;
            end
            StResp: begin
                if (rsp_hs) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus a randomized run against a transaction model.
// Build with +define+ALU_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp_result, alu_a, alu_b, alu_result;
    logic        rsp_zero, alu_zero, busy;
    logic [3:0]  alu_op;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            default: return 32'd0;
        endcase
    endfunction

    // Behavioural ALU sitting outside the arbiter
    assign alu_result = alu_ref(alu_a, alu_b, alu_op);
    assign alu_zero   = (alu_result == 32'd0);

    alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_a_i(req0_a),
        .req0_b_i(req0_b), .req0_op_i(req0_op), .rsp0_valid_o(rsp0_valid),
        .rsp0_ready_i(rsp0_ready),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_a_i(req1_a),
        .req1_b_i(req1_b), .req1_op_i(req1_op), .rsp1_valid_o(rsp1_valid),
        .rsp1_ready_i(rsp1_ready),
        .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op),
        .alu_result_i(alu_result), .alu_zero_i(alu_zero), .busy_o(busy)
    );

    task automatic apply_reset();
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(negedge clk); rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk); rst_n = 1'b0; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_cmp++; if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b0) begin
            n_err++; $display("FAIL rst_handshake got=%b exp=0000",
                              {rsp0_valid, rsp1_valid, req0_ready, req1_ready}); end
        n_cmp++; if ({rsp_result, rsp_zero} !== 33'd0) begin
            n_err++; $display("FAIL rst_rsp got=%h/%b exp=0/0", rsp_result, rsp_zero); end
        n_cmp++; if ({alu_a, alu_b, alu_op} !== 68'd0) begin
            n_err++; $display("FAIL rst_alu got=%h/%h/%h exp=0", alu_a, alu_b, alu_op); end
        @(negedge clk); rst_n = 1'b1;
        // First tie after reset must go to requester 0
        req0_valid = 1'b1; req1_valid = 1'b1; #1;
        n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin
            n_err++; $display("FAIL rst_first_tie got=%b exp=10", {req0_ready, req1_ready}); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_one_op(input int who, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] op, input logic [31:0] exp_res,
                               input logic exp_z);
        logic rv, ov;
        if (who == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end
        @(negedge clk);
        rv = (who == 0) ? req0_ready : req1_ready;
        n_cmp++; if (rv !== 1'b1) begin n_err++; $display("FAIL op%0d_ready got=%b exp=1", who, rv); end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b100) begin
            n_err++; $display("FAIL op%0d_exec got=%b exp=100", who, {busy, rsp0_valid, rsp1_valid});
        end
        n_cmp++; if ({alu_a, alu_b, alu_op} !== {a, b, op}) begin
            n_err++; $display("FAIL op%0d_alu got=%h/%h/%h exp=%h/%h/%h", who, alu_a, alu_b,
                              alu_op, a, b, op); end
        @(posedge clk); #1;
        @(negedge clk);
        rv = (who == 0) ? rsp0_valid : rsp1_valid;
        ov = (who == 0) ? rsp1_valid : rsp0_valid;
        n_cmp++; if ({rv, ov} !== 2'b10) begin
            n_err++; $display("FAIL op%0d_rsp_valid got=%b exp=10", who, {rv, ov}); end
        n_cmp++; if ({rsp_result, rsp_zero} !== {exp_res, exp_z}) begin
            n_err++; $display("FAIL op%0d_result got=%h/%b exp=%h/%b", who, rsp_result, rsp_zero,
                              exp_res, exp_z); end
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL op%0d_idle got=%b exp=0", who, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_tie();
        int grants[$];
        int gcyc[$];
        int exp_g[4];
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        apply_reset();
        req0_valid = 1'b1; req0_a = 32'hF0; req0_b = 32'hFF; req0_op = 4'd2;
        req1_valid = 1'b1; req1_a = 32'h0F; req1_b = 32'hF0; req1_op = 4'd3;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req0_ready) begin grants.push_back(0); gcyc.push_back(c); end
            if (req1_ready) begin grants.push_back(1); gcyc.push_back(c); end
            if (rsp0_valid) begin
                n_cmp++; if (rsp_result !== 32'hF0) begin
                    n_err++; $display("FAIL tie_rsp0 got=%h exp=f0", rsp_result); end
            end
            if (rsp1_valid) begin
                n_cmp++; if (rsp_result !== 32'hFF) begin
                    n_err++; $display("FAIL tie_rsp1 got=%h exp=ff", rsp_result); end
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        n_cmp++; if (grants.size() !== 4) begin
            n_err++; $display("FAIL tie_count got=%0d exp=4", grants.size()); end
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            n_cmp++; if (grants[i] !== exp_g[i] || gcyc[i] !== 3 * i) begin
                n_err++; $display("FAIL tie_grant%0d got=%0d@%0d exp=%0d@%0d", i, grants[i],
                                  gcyc[i], exp_g[i], 3 * i); end
        end
    endtask

    task automatic test_stall();
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 4'd0;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd9; req1_b = 32'd4; req1_op = 4'd1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if (req1_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_ready1 cyc=%0d got=%b exp=0", i, req1_ready); end
            if (i >= 1) begin
                n_cmp++; if ({rsp0_valid, rsp_result} !== {1'b1, 32'd12}) begin
                    n_err++; $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/c", i, rsp0_valid,
                                      rsp_result); end
            end
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b1;
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (req1_ready !== 1'b1) begin
            n_err++; $display("FAIL stall_grant1 got=%b exp=1", req1_ready); end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if ({rsp1_valid, rsp_result, rsp_zero} !== {1'b1, 32'd5, 1'b0}) begin
            n_err++; $display("FAIL stall_rsp1 got=%b/%h/%b exp=1/5/0", rsp1_valid, rsp_result,
                              rsp_zero); end
        rsp1_ready = 1'b1;
        @(posedge clk); #1;
        rsp1_ready = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        req0_valid = 1'b1; req0_a = 32'h3; req0_b = 32'h4; req0_op = 4'd3;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0; #1;
        n_cmp++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
            n_err++; $display("FAIL midrst_ctrl got=%b exp=000", {busy, rsp0_valid, rsp1_valid});
        end
        n_cmp++; if ({alu_op, alu_a, rsp_result} !== 68'd0) begin
            n_err++; $display("FAIL midrst_regs got=%h/%h/%h exp=0", alu_op, alu_a, rsp_result);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin
                n_err++; $display("FAIL midrst_after got=%b exp=000",
                                  {busy, rsp0_valid, rsp1_valid}); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic        pv[2];
        logic [31:0] pa[2], pb[2];
        logic [3:0]  pop[2];
        logic [31:0] ea, eb, exp_res;
        logic [3:0]  eop;
        logic        in_flight, g0, g1, rdy;
        int          age, own, last;
        apply_reset();
        in_flight = 1'b0; age = 0; own = 0; last = 1;
        ea = '0; eb = '0; eop = '0; exp_res = '0;
        pv[0] = 1'b0; pv[1] = 1'b0;
        for (int c = 0; c < 800; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pv[r] && $urandom_range(0, 2) == 0) begin
                    pv[r] = 1'b1;
                    pa[r] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                    pb[r] = ($urandom_range(0, 3) == 0) ? pa[r] : $urandom;
                    pop[r] = 4'($urandom_range(0, 5));
                end else if (pv[r] && $urandom_range(0, 15) == 0) begin
                    pv[r] = 1'b0;
                end
            end
            req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
            req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
            g0 = 1'b0; g1 = 1'b0;
            if (!in_flight) begin
                if (pv[0] && pv[1]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                    g0 = 1'b1;
`else
                    g0 = (last == 1); g1 = (last == 0);
`endif
                end else begin
                    g0 = pv[0]; g1 = pv[1];
                end
            end
            @(negedge clk);
            n_cmp++; if ({req0_ready, req1_ready, busy} !== {g0, g1, in_flight}) begin
                n_err++; $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", c,
                                  {req0_ready, req1_ready, busy}, {g0, g1, in_flight}); end
            n_cmp++; if ({rsp0_valid, rsp1_valid} !== {in_flight && age >= 1 && own == 0,
                                                       in_flight && age >= 1 && own == 1}) begin
                n_err++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b own=%0d age=%0d busy=%b", c,
                                  {rsp0_valid, rsp1_valid}, own, age, in_flight); end
            if (in_flight && age == 0) begin
                n_cmp++; if ({alu_a, alu_b, alu_op} !== {ea, eb, eop}) begin
                    n_err++; $display("FAIL rnd_alu cyc=%0d got=%h/%h/%h exp=%h/%h/%h", c, alu_a,
                                      alu_b, alu_op, ea, eb, eop); end
            end
            if (in_flight && age >= 1) begin
                n_cmp++; if ({rsp_result, rsp_zero} !== {exp_res, exp_res == 32'd0}) begin
                    n_err++; $display("FAIL rnd_result cyc=%0d got=%h/%b exp=%h/%b", c,
                                      rsp_result, rsp_zero, exp_res, exp_res == 32'd0); end
            end
            @(posedge clk);
            if (in_flight) begin
                rdy = (own == 0) ? rsp0_ready : rsp1_ready;
                if (age >= 1 && rdy) begin
                    in_flight = 1'b0; last = own;
                end else begin
                    age = 1;
                end
            end else if (g0 || g1) begin
                own = g1 ? 1 : 0;
                in_flight = 1'b1; age = 0;
                ea = pa[own]; eb = pb[own]; eop = pop[own];
                exp_res = alu_ref(ea, eb, eop);
                pv[own] = 1'b0;
            end
            #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_one_op(0, 32'd5, 32'd7, 4'd0, 32'd12, 1'b0);
        test_one_op(1, 32'h10, 32'h10, 4'd1, 32'd0, 1'b1);
        test_one_op(0, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b1);
        test_one_op(1, 32'h1234, 32'h5678, 4'd9, 32'd0, 1'b1);
        test_tie();
        test_stall();
        test_reset_mid_exec();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
